// File: rtl/mfp_irq_pkg.sv
// Shared constants and types for the MFP interrupt controller.
package mfp_irq_pkg;

  localparam int unsigned NumCh = 16;

  localparam logic [3:0] AddrIera = 4'd0;
  localparam logic [3:0] AddrIerb = 4'd1;
  localparam logic [3:0] AddrIpra = 4'd2;
  localparam logic [3:0] AddrIprb = 4'd3;
  localparam logic [3:0] AddrIsra = 4'd4;
  localparam logic [3:0] AddrIsrb = 4'd5;
  localparam logic [3:0] AddrImra = 4'd6;
  localparam logic [3:0] AddrImrb = 4'd7;
  localparam logic [3:0] AddrVr   = 4'd8;

  localparam logic [7:0] DefaultSpuriousVec = 8'h18;

  typedef enum logic {StIdle, StVect} ack_state_e;

endpackage

// File: rtl/mfp_irq_prio.sv
// Highest-set-bit encoder over the 16 interrupt channels; channel 15 wins.
module mfp_irq_prio
  import mfp_irq_pkg::*;
(
  input  logic [NumCh-1:0] i_bits,
  output logic [3:0]       o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx   = 4'd0;
    o_valid = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      if (i_bits[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// MFP68901 interrupt controller: enable/pending/in-service/mask registers,
// priority request generation and the interrupt-acknowledge vector cycle.
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
#(
  parameter logic [7:0] SPURIOUS_VEC = DefaultSpuriousVec
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  input  logic [15:0] i_irq,
  input  logic        i_iack,
  output logic        o_irq_n,
  output logic [7:0]  o_vec,
  output logic        o_vec_valid
);

  logic [15:0] r_ier, r_ipr, r_isr, r_imr, r_prev_irq;
  logic [4:0]  r_vr;  // VR[7:3]; r_vr[0] is the software-EOI bit S
  logic        r_irq_n;
  logic [7:0]  r_vec;
  logic        r_vec_valid;
  ack_state_e  r_state;

  logic [15:0] w_ier_d, w_ipr_d, w_isr_d, w_imr_d;
  logic [4:0]  w_vr_d;
  logic [7:0]  w_vec_d;
  logic        w_vec_valid_d;
  ack_state_e  w_state_d;

  logic [15:0] w_pend, w_edge;
  logic [3:0]  w_h, w_s;
  logic        w_h_valid, w_s_valid, w_req, w_wr, w_ack_clr;

  assign w_pend = r_ipr & r_imr;
  assign w_edge = i_irq & ~r_prev_irq;
  assign w_wr   = i_sel & i_we;

  mfp_irq_prio u_prio_pend (
    .i_bits  (w_pend),
    .o_idx   (w_h),
    .o_valid (w_h_valid)
  );

  mfp_irq_prio u_prio_isr (
    .i_bits  (r_isr),
    .o_idx   (w_s),
    .o_valid (w_s_valid)
  );

  assign w_req = w_h_valid & (~w_s_valid | (w_h > w_s));

  always_comb begin
    w_state_d     = r_state;
    w_vec_d       = r_vec;
    w_vec_valid_d = 1'b0;
    w_ack_clr     = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_iack) begin
          w_vec_valid_d = 1'b1;
          w_state_d     = StVect;
          if (w_req) begin
            w_ack_clr = 1'b1;
            w_vec_d   = {r_vr[4:1], w_h};
          end else begin
            w_vec_d = SPURIOUS_VEC;
          end
        end
      end
      StVect:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Write clears first, then the acknowledge clear, then event sets win.
  always_comb begin
    w_ier_d = r_ier;
    w_ipr_d = r_ipr;
    w_isr_d = r_isr;
    w_imr_d = r_imr;
    w_vr_d  = r_vr;
    if (w_wr) begin
      case (i_addr)
        AddrIera: begin
          w_ier_d[15:8] = i_dat;
          w_ipr_d[15:8] = r_ipr[15:8] & i_dat;
        end
        AddrIerb: begin
          w_ier_d[7:0] = i_dat;
          w_ipr_d[7:0] = r_ipr[7:0] & i_dat;
        end
        AddrIpra: w_ipr_d[15:8] = r_ipr[15:8] & i_dat;
        AddrIprb: w_ipr_d[7:0]  = r_ipr[7:0] & i_dat;
        AddrIsra: w_isr_d[15:8] = r_isr[15:8] & i_dat;
        AddrIsrb: w_isr_d[7:0]  = r_isr[7:0] & i_dat;
        AddrImra: w_imr_d[15:8] = i_dat;
        AddrImrb: w_imr_d[7:0]  = i_dat;
        AddrVr: begin
          w_vr_d = i_dat[7:3];
          if (!i_dat[3]) w_isr_d = '0;
        end
        default: ;
      endcase
    end
    if (w_ack_clr) begin
      w_ipr_d[w_h] = 1'b0;
      if (r_vr[0]) w_isr_d[w_h] = 1'b1;
    end
    w_ipr_d = w_ipr_d | (w_edge & r_ier);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ier       <= '0;
      r_ipr       <= '0;
      r_isr       <= '0;
      r_imr       <= '0;
      r_vr        <= '0;
      r_prev_irq  <= '0;
      r_irq_n     <= 1'b1;
      r_vec       <= 8'h00;
      r_vec_valid <= 1'b0;
      r_state     <= StIdle;
    end else begin
      r_ier       <= w_ier_d;
      r_ipr       <= w_ipr_d;
      r_isr       <= w_isr_d;
      r_imr       <= w_imr_d;
      r_vr        <= w_vr_d;
      r_prev_irq  <= i_irq;
      r_irq_n     <= ~w_req;
      r_vec       <= w_vec_d;
      r_vec_valid <= w_vec_valid_d;
      r_state     <= w_state_d;
    end
  end

  always_comb begin
    o_dat = 8'h00;
    case (i_addr)
      AddrIera: o_dat = r_ier[15:8];
      AddrIerb: o_dat = r_ier[7:0];
      AddrIpra: o_dat = r_ipr[15:8];
      AddrIprb: o_dat = r_ipr[7:0];
      AddrIsra: o_dat = r_isr[15:8];
      AddrIsrb: o_dat = r_isr[7:0];
      AddrImra: o_dat = r_imr[15:8];
      AddrImrb: o_dat = r_imr[7:0];
      AddrVr:   o_dat = {r_vr, 3'b000};
      default:  o_dat = 8'h00;
    endcase
  end

  assign o_irq_n     = r_irq_n;
  assign o_vec       = r_vec;
  assign o_vec_valid = r_vec_valid;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Bench for mfp_irq_ctrl: directed scenarios plus random traffic against a reference model.
module tb_mfp_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, we, iack;
  logic [3:0]  addr;
  logic [7:0]  dat_i, dat_o;
  logic [15:0] irq;
  logic        irq_n, vec_valid;
  logic [7:0]  vec;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_ier, m_ipr, m_isr, m_imr, m_prev;
  logic [7:0]  m_vr, m_vec;
  logic        m_irq_n, m_valid, m_busy;

  always #5 clk = ~clk;

  mfp_irq_ctrl #(.SPURIOUS_VEC(8'h18)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sel       (sel),
    .i_we        (we),
    .i_addr      (addr),
    .i_dat       (dat_i),
    .o_dat       (dat_o),
    .i_irq       (irq),
    .i_iack      (iack),
    .o_irq_n     (irq_n),
    .o_vec       (vec),
    .o_vec_valid (vec_valid)
  );

  function automatic int top_bit(input logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return m_ier[15:8];
      4'd1:    return m_ier[7:0];
      4'd2:    return m_ipr[15:8];
      4'd3:    return m_ipr[7:0];
      4'd4:    return m_isr[15:8];
      4'd5:    return m_isr[7:0];
      4'd6:    return m_imr[15:8];
      4'd7:    return m_imr[7:0];
      4'd8:    return m_vr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0; m_prev = '0;
    m_vr = '0; m_vec = '0; m_irq_n = 1'b1; m_valid = 1'b0; m_busy = 1'b0;
  endtask

  // One clock of the controller, from the behavioural rules.
  task automatic model_clock();
    int p, s;
    logic req;
    logic [15:0] ev;
    logic [7:0] vr_old;
    p = top_bit(m_ipr & m_imr);
    s = top_bit(m_isr);
    req = (p >= 0) && (p > s);
    ev = irq & ~m_prev & m_ier;
    vr_old = m_vr;
    if (sel && we) begin
      case (addr)
        4'd0: begin m_ier[15:8] = dat_i; m_ipr[15:8] &= dat_i; end
        4'd1: begin m_ier[7:0] = dat_i; m_ipr[7:0] &= dat_i; end
        4'd2: m_ipr[15:8] &= dat_i;
        4'd3: m_ipr[7:0] &= dat_i;
        4'd4: m_isr[15:8] &= dat_i;
        4'd5: m_isr[7:0] &= dat_i;
        4'd6: m_imr[15:8] = dat_i;
        4'd7: m_imr[7:0] = dat_i;
        4'd8: begin m_vr = dat_i & 8'hF8; if (!dat_i[3]) m_isr = '0; end
        default: ;
      endcase
    end
    if (iack && !m_busy) begin
      m_valid = 1'b1;
      m_busy = 1'b1;
      if (req) begin
        m_ipr[p[3:0]] = 1'b0;
        if (vr_old[3]) m_isr[p[3:0]] = 1'b1;
        m_vec = {vr_old[7:4], p[3:0]};
      end else begin
        m_vec = 8'h18;
      end
    end else begin
      m_valid = 1'b0;
      m_busy = 1'b0;
    end
    m_ipr |= ev;
    m_prev = irq;
    m_irq_n = !req;
  endtask

  task automatic step(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic k);
    sel = s; we = w; addr = a; dat_i = d; iack = k;
    @(posedge clk);
    model_clock();
    #1;
    sel = 1'b0; we = 1'b0; iack = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, addr, 8'h00, 1'b0);
  endtask

  task automatic ack();
    step(1'b0, 1'b0, addr, 8'h00, 1'b1);
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq = 16'hFFFF; sel = 0; we = 0; iack = 0; addr = 4'd2; dat_i = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (irq_n !== 1'b1 || dat_o !== 8'h00) begin
        errors++; $display("FAIL reset_hold: irq_n=%b ipra=%h, want 1 00", irq_n, dat_o);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    idle(); idle();
    wr(4'd0, 8'hFF);
    idle();
    rd(4'd2); checks++;
    if (dat_o !== 8'h00) begin errors++; $display("FAIL reset_ipra: got %h want 00", dat_o); end
    rd(4'd3); checks++;
    if (dat_o !== 8'h00) begin errors++; $display("FAIL reset_iprb: got %h want 00", dat_o); end
    checks++;
    if (irq_n !== 1'b1 || vec_valid !== 1'b0 || vec !== 8'h00) begin
      errors++; $display("FAIL reset_outs: irq_n=%b vv=%b vec=%h, want 1 0 00", irq_n, vec_valid, vec);
    end
    wr(4'd0, 8'h00);
    irq = 16'h0000;
    idle();
  endtask

  task automatic test_basic();
    wr(4'd1, 8'h20); wr(4'd7, 8'h20); wr(4'd8, 8'h48);
    irq = 16'h0020; idle();
    rd(4'd3); checks++;
    if (dat_o !== 8'h20 || irq_n !== 1'b1) begin
      errors++; $display("FAIL basic_pend: iprb=%h irq_n=%b, want 20 1", dat_o, irq_n);
    end
    irq = 16'h0000; idle();
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL basic_irq_low: got %b want 0", irq_n); end
    ack();
    checks++;
    if (vec_valid !== 1'b1 || vec !== 8'h45) begin
      errors++; $display("FAIL basic_vec: vv=%b vec=%h, want 1 45", vec_valid, vec);
    end
    idle();
    checks++;
    if (vec_valid !== 1'b0 || irq_n !== 1'b1) begin
      errors++; $display("FAIL basic_after: vv=%b irq_n=%b, want 0 1", vec_valid, irq_n);
    end
    rd(4'd5); checks++;
    if (dat_o !== 8'h20) begin errors++; $display("FAIL basic_isrb: got %h want 20", dat_o); end
    rd(4'd3); checks++;
    if (dat_o !== 8'h00) begin errors++; $display("FAIL basic_iprb: got %h want 00", dat_o); end
  endtask

  task automatic test_nesting();
    wr(4'd5, 8'h00);
    wr(4'd0, 8'hFF); wr(4'd1, 8'hFF); wr(4'd6, 8'hFF); wr(4'd7, 8'hFF); wr(4'd8, 8'h48);
    irq = 16'h0008; idle(); irq = 16'h0000; idle();
    ack();
    checks++;
    if (vec !== 8'h43 || vec_valid !== 1'b1) begin
      errors++; $display("FAIL nest_vec3: vec=%h vv=%b, want 43 1", vec, vec_valid);
    end
    idle();
    irq = 16'h0004; idle(); irq = 16'h0000; idle(); idle();
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL nest_lower_blocked: got %b want 1", irq_n); end
    irq = 16'h2000; idle(); irq = 16'h0000; idle();
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL nest_higher_req: got %b want 0", irq_n); end
    ack();
    checks++;
    if (vec !== 8'h4D || vec_valid !== 1'b1) begin
      errors++; $display("FAIL nest_vec13: vec=%h vv=%b, want 4d 1", vec, vec_valid);
    end
    idle();
    wr(4'd4, 8'hDF);
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL nest_still_blocked: got %b want 1", irq_n); end
    wr(4'd5, 8'hF7);
    idle();
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL nest_rerequest: got %b want 0", irq_n); end
    ack();
    checks++;
    if (vec !== 8'h42) begin errors++; $display("FAIL nest_vec2: got %h want 42", vec); end
    idle();
    wr(4'd8, 8'h40);
  endtask

  task automatic test_aeoi();
    irq = 16'h8001; idle(); irq = 16'h0000; idle();
    ack();
    checks++;
    if (vec !== 8'h4F || vec_valid !== 1'b1) begin
      errors++; $display("FAIL aeoi_vec15: vec=%h vv=%b, want 4f 1", vec, vec_valid);
    end
    idle();
    ack();
    checks++;
    if (vec !== 8'h40 || vec_valid !== 1'b1) begin
      errors++; $display("FAIL aeoi_vec0: vec=%h vv=%b, want 40 1", vec, vec_valid);
    end
    idle();
    rd(4'd4); checks++;
    if (dat_o !== 8'h00) begin errors++; $display("FAIL aeoi_isra: got %h want 00", dat_o); end
    rd(4'd5); checks++;
    if (dat_o !== 8'h00) begin errors++; $display("FAIL aeoi_isrb: got %h want 00", dat_o); end
    idle();
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL aeoi_idle: got %b want 1", irq_n); end
  endtask

  task automatic test_conflicts();
    irq = 16'h0002; idle(); irq = 16'h0000; idle();
    irq = 16'h0002; wr(4'd3, 8'hFD);
    rd(4'd3); checks++;
    if (dat_o !== 8'h02) begin errors++; $display("FAIL conf_write_vs_event: got %h want 02", dat_o); end
    irq = 16'h0000; wr(4'd3, 8'h00); idle();
    ack();
    checks++;
    if (vec !== 8'h18 || vec_valid !== 1'b1) begin
      errors++; $display("FAIL conf_spurious: vec=%h vv=%b, want 18 1", vec, vec_valid);
    end
    ack();
    checks++;
    if (vec_valid !== 1'b0) begin errors++; $display("FAIL conf_vect_ignored: got %b want 0", vec_valid); end
    idle();
    irq = 16'h0010; idle(); irq = 16'h0000; idle();
    irq = 16'h0010; ack();
    checks++;
    if (vec !== 8'h44) begin errors++; $display("FAIL conf_ack_vec: got %h want 44", vec); end
    rd(4'd3); checks++;
    if (dat_o !== 8'h10) begin errors++; $display("FAIL conf_ack_vs_event: got %h want 10", dat_o); end
    irq = 16'h0000; idle(); wr(4'd3, 8'h00); idle();
  endtask

  task automatic test_random();
    logic s, k;
    logic [3:0] a;
    logic [7:0] d;
    for (int n = 0; n < 400; n++) begin
      irq = irq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      s = ($urandom_range(0, 7) == 0);
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      k = ($urandom_range(0, 3) == 0);
      step(s, s, a, d, k);
      checks++;
      if (irq_n !== m_irq_n) begin
        errors++; $display("FAIL rand_irq_n[%0d]: got %b want %b", n, irq_n, m_irq_n);
      end
      checks++;
      if (vec_valid !== m_valid) begin
        errors++; $display("FAIL rand_vv[%0d]: got %b want %b", n, vec_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (vec !== m_vec) begin errors++; $display("FAIL rand_vec[%0d]: got %h want %h", n, vec, m_vec); end
      end
      checks++;
      if (dat_o !== m_read(a)) begin
        errors++; $display("FAIL rand_dat[%0d] addr %0d: got %h want %h", n, a, dat_o, m_read(a));
      end
    end
    irq = 16'h0000; idle(); idle();
  endtask

  task automatic test_reset_mid_ack();
    wr(4'd8, 8'h48);
    idle(); idle();
    ack();
    checks++;
    if (vec_valid !== 1'b1) begin errors++; $display("FAIL rst_ack_valid: got %b want 1", vec_valid); end
    rd(4'd8);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (vec_valid !== 1'b0 || irq_n !== 1'b1 || vec !== 8'h00 || dat_o !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: vv=%b irq_n=%b vec=%h vr=%h, want 0 1 00 00", vec_valid, irq_n, vec, dat_o);
    end
    @(negedge clk) rst_n = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_aeoi();
    test_conflicts();
    test_random();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
